// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code decoder.
// Holds the FSM state enum, prefix/control byte values and the key event bundle.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_E0,
    PRE_F0,
    PRE_E0F0,
    PAUSE
  } state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } key_evt_t;

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// FIFO pop port and key event port of the scan-code decoder.
// master = decoder side, slave = FIFO/consumer side.
interface ps2_scancode_decoder_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_repeat;
  logic [7:0] evt_ascii;

  modport master (
    input  kbd_data,
    input  kbd_ready,
    output kbd_nextdata_n,
    output evt_valid,
    input  evt_ready,
    output evt_code,
    output evt_ext,
    output evt_break,
    output evt_repeat,
    output evt_ascii
  );

  modport slave (
    output kbd_data,
    output kbd_ready,
    input  kbd_nextdata_n,
    input  evt_valid,
    output evt_ready,
    input  evt_code,
    input  evt_ext,
    input  evt_break,
    input  evt_repeat,
    input  evt_ascii
  );
endinterface

// File: rtl/ps2_scancode_decoder_ascii_lut.sv
// Set-2 make code to ASCII: letters, digits, space, enter, backspace.
// Unmapped codes return 0x00.
module ps2_ascii_lut (
  input  logic [7:0] code,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      default: ascii = 8'h00;
    endcase
  end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds E0/F0/E1 scan-code sequences into key events with repeat
// detection, press counting and a registered valid/ready output.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TO_CYCLES = 1000000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  ps2_scancode_decoder_if.master bus,
  output logic [CNT_W-1:0] key_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state, state_n;
  logic [2:0]      skip, skip_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  key_evt_t        evt, evt_n;
  logic            evt_valid;
  logic            emit, err_hit, pause_evt;
  logic            held_v, held_ext;
  logic [7:0]      held_code;
  logic [7:0]      b;
  logic [7:0]      lut_ascii;
  logic            pop;

  assign b   = bus.kbd_data;
  assign pop = bus.kbd_ready && (!evt_valid || bus.evt_ready);
  assign bus.kbd_nextdata_n = !pop;

  always_comb begin
    state_n   = state;
    skip_n    = skip;
    to_cnt_n  = to_cnt;
    emit      = 1'b0;
    err_hit   = 1'b0;
    pause_evt = 1'b0;
    evt_n     = '{code: b, ext: 1'b0, brk: 1'b0, rpt: 1'b0};
    if (pop) begin
      to_cnt_n = '0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            (b == SC_EXT):   state_n = PRE_E0;
            (b == SC_BRK):   state_n = PRE_F0;
            (b == SC_PAUSE): begin
              state_n = PAUSE;
              skip_n  = PAUSE_SKIP;
            end
            (b == SC_ERR0 || b == SC_ERR1): err_hit = 1'b1;
            (b == SC_BAT || b == SC_ACK ||
             b == SC_ECHO || b == SC_RESEND): begin
            end
            default: emit = 1'b1;
          endcase
        end
        PRE_E0: begin
          if (b == SC_BRK) begin
            state_n = PRE_E0F0;
          end else begin
            emit      = 1'b1;
            evt_n.ext = 1'b1;
            state_n   = IDLE;
          end
        end
        PRE_F0: begin
          emit      = 1'b1;
          evt_n.brk = 1'b1;
          state_n   = IDLE;
        end
        PRE_E0F0: begin
          emit      = 1'b1;
          evt_n.ext = 1'b1;
          evt_n.brk = 1'b1;
          state_n   = IDLE;
        end
        PAUSE: begin
          skip_n = skip - 3'd1;
          if (skip <= 3'd1) begin
            emit       = 1'b1;
            pause_evt  = 1'b1;
            evt_n.code = SC_PAUSE;
            state_n    = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      // stale prefix: drop it silently
      if (to_cnt == TO_LAST) begin
        state_n  = IDLE;
        to_cnt_n = '0;
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end
    if (emit && !evt_n.brk && !pause_evt)
      evt_n.rpt = held_v && (held_ext == evt_n.ext) &&
                  (held_code == evt_n.code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      skip      <= '0;
      to_cnt    <= '0;
      evt       <= '0;
      evt_valid <= 1'b0;
      held_v    <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= '0;
      key_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state  <= state_n;
      skip   <= skip_n;
      to_cnt <= to_cnt_n;
      if (pop && err_hit && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
      if (pop && emit) begin
        evt       <= evt_n;
        evt_valid <= 1'b1;
        if (!evt_n.brk) begin
          if (!evt_n.rpt) begin
            held_v    <= 1'b1;
            held_ext  <= evt_n.ext;
            held_code <= evt_n.code;
            key_cnt   <= key_cnt + 1'b1;
          end
        end else if (held_v && held_ext == evt_n.ext &&
                     held_code == evt_n.code) begin
          held_v <= 1'b0;
        end
      end else if (bus.evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

  ps2_ascii_lut u_lut (
    .code  (evt.code),
    .ascii (lut_ascii)
  );

  assign bus.evt_valid  = evt_valid;
  assign bus.evt_code   = evt.code;
  assign bus.evt_ext    = evt.ext;
  assign bus.evt_break  = evt.brk;
  assign bus.evt_repeat = evt.rpt;
  assign bus.evt_ascii  = evt.ext ? 8'h00 : lut_ascii;

endmodule
